// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, default base address, FSM encoding
// and the request fields latched during the setup phase.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_CNT_W  = 4;
    localparam int unsigned APB_MAX_WAIT = 15;

    localparam logic [APB_ADDR_W-1:0] APB_BASE_ADDR_DFLT = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage : apb_pkg

// File: rtl/apb_regfile.sv
// NUM_REGS x 32-bit register storage: synchronous write, combinational read,
// synchronous clear, and a tap of register 0.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata_c,
    output logic [APB_DATA_W-1:0] reg0
);

    logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
    logic [APB_DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[widx] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_c = regs_q[ridx];
    assign reg0    = regs_q[0];

endmodule : apb_regfile

// File: rtl/apb_slave_regfile.sv
// APB completer with a small register file, programmable wait states and
// pslverr on out-of-range or misaligned accesses; register 0 drives ctrl_out.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = APB_BASE_ADDR_DFLT,
    parameter int unsigned           NUM_REGS    = 16,
    parameter int unsigned           WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [APB_DATA_W-1:0] ctrl_out
);

    localparam int unsigned IDX_W   = $clog2(NUM_REGS);
    localparam int unsigned CNT_W   = APB_CNT_W;
    localparam logic [APB_ADDR_W-1:0] SPAN = APB_ADDR_W'(4 * NUM_REGS);

    if (WAIT_CYCLES > APB_MAX_WAIT) begin : g_bad_wait
        $error("apb_slave_regfile: WAIT_CYCLES must be in 0..15");
    end
    if ((NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0)) begin : g_bad_regs
        $error("apb_slave_regfile: NUM_REGS must be a power of 2 and >= 2");
    end

    apb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    apb_req_t              req_q, req_d;
    logic [APB_DATA_W-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [APB_ADDR_W-1:0] rd_off_c, wr_off_c;
    logic                  rd_hit_c, wr_hit_c;
    logic                  we_c;
    logic [APB_DATA_W-1:0] rdata_c;

    // Transfer sequencing: setup latch, wait countdown, single-cycle completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    req_d.write = pwrite;
                    req_d.addr  = paddr;
                    req_d.wdata = pwdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                we_c    = req_q.write && wr_hit_c;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode of the request being committed (write) and the one completing next (read)
    always_comb begin
        wr_off_c = req_q.addr - BASE_ADDR;
        wr_hit_c = (wr_off_c[1:0] == 2'b00) && (wr_off_c < SPAN);
        rd_off_c = req_d.addr - BASE_ADDR;
        rd_hit_c = (rd_off_c[1:0] == 2'b00) && (rd_off_c < SPAN);
    end

    // Response registers are loaded on the edge that enters DONE
    always_comb begin
        pready_d  = (state_d == DONE);
        pslverr_d = pready_d && !rd_hit_c;
        prdata_d  = '0;
        if (pready_d && rd_hit_c && !req_d.write) begin
            prdata_d = rdata_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    apb_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (we_c),
        .widx    (wr_off_c[IDX_W+1:2]),
        .wdata   (req_q.wdata),
        .ridx    (rd_off_c[IDX_W+1:2]),
        .rdata_c (rdata_c),
        .reg0    (ctrl_out)
    );

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule : apb_slave_regfile
